// File: rtl/frame_tx_packer_if.sv
// Stream-in / frame-out bus bundle for frame_tx_packer.
// The producer side (stream words, frame marks, receiver ready) is driven by
// the master; the packer owns o_data/o_valid as the slave.
interface frame_tx_packer_if;
    logic        i_sync;
    logic [31:0] i_data;
    logic        i_valid;
    logic [7:0]  i_ch;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_rcv_rdy;

    modport master (
        output i_sync, i_data, i_valid, i_ch, i_rcv_rdy,
        input  o_data, o_valid
    );

    modport slave (
        input  i_sync, i_data, i_valid, i_ch, i_rcv_rdy,
        output o_data, o_valid
    );
endinterface

// File: rtl/frame_tx_packer.sv
// frame_tx_packer: buffers one frame of stream words between two falling
// edges of i_sync, then emits a header word and the buffered payload under
// ready/valid backpressure. Marks arriving while a frame is being sent are
// counted as dropped frames.
module frame_tx_packer #(
    parameter int          ADDR_W  = 8,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    frame_tx_packer_if.slave   bus,
    output logic               o_busy,
    output logic               o_trunc,
    output logic [15:0]        o_drop_cnt
);

    localparam int MAX_WORDS = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HDR  = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    // Header length field: frame length zero-extended to 16 bits.
    function automatic logic [15:0] len_to_hdr(input logic [ADDR_W:0] len);
        logic [15:0] v;
        v = 16'd0;
        v[ADDR_W:0] = len;
        return v;
    endfunction

    state_t              state_r, state_nxt;
    logic                sync_d_r;
    logic                mark_s;
    logic                xfer_s;
    logic                full_s;
    logic                we_s;
    logic [ADDR_W:0]     wr_ptr_r, wr_ptr_nxt;
    logic [ADDR_W:0]     rd_ptr_r, rd_ptr_nxt;
    logic [ADDR_W:0]     len_lat_r, len_lat_nxt;
    logic [7:0]          ch_lat_r, ch_lat_nxt;
    logic [31:0]         o_data_r, o_data_nxt;
    logic                o_valid_r, o_valid_nxt;
    logic                o_trunc_r, o_trunc_nxt;
    logic [15:0]         drop_cnt_r, drop_cnt_nxt;
    logic                o_busy_r;
    logic [31:0]         rd_data_r;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [31:0]         mem_r [MAX_WORDS];

    assign mark_s    = sync_d_r & ~bus.i_sync;
    assign xfer_s    = o_valid_r & bus.i_rcv_rdy;
    assign full_s    = wr_ptr_r[ADDR_W];
    assign wr_addr_s = wr_ptr_r[ADDR_W-1:0];
    // The RAM is always addressed with the pointer it will hold next cycle,
    // so rd_data_r tracks buf[rd_ptr_r] and a transfer can consume it at once.
    assign rd_addr_s = rd_ptr_nxt[ADDR_W-1:0];

    assign bus.o_data  = o_data_r;
    assign bus.o_valid = o_valid_r;
    assign o_busy      = o_busy_r;
    assign o_trunc     = o_trunc_r;
    assign o_drop_cnt  = drop_cnt_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state, pointer and output-word decisions.
    always_comb begin
        state_nxt    = state_r;
        wr_ptr_nxt   = wr_ptr_r;
        rd_ptr_nxt   = rd_ptr_r;
        len_lat_nxt  = len_lat_r;
        ch_lat_nxt   = ch_lat_r;
        o_data_nxt   = o_data_r;
        o_valid_nxt  = o_valid_r;
        o_trunc_nxt  = o_trunc_r;
        drop_cnt_nxt = drop_cnt_r;
        we_s         = 1'b0;

        // A mark while the previous frame is still going out is a dropped frame.
        if (mark_s && ((state_r == ST_HDR) || (state_r == ST_SEND))) begin
            if (drop_cnt_r != 16'hFFFF) begin
                drop_cnt_nxt = drop_cnt_r + 16'd1;
            end else begin
                drop_cnt_nxt = drop_cnt_r;
            end
        end else begin
            drop_cnt_nxt = drop_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (mark_s) begin
                    ch_lat_nxt  = bus.i_ch;
                    wr_ptr_nxt  = PTR_ZERO;
                    rd_ptr_nxt  = PTR_ZERO;
                    o_trunc_nxt = 1'b0;
                    state_nxt   = ST_FILL;
                end else begin
                    state_nxt   = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (bus.i_valid) begin
                    if (!full_s) begin
                        we_s       = 1'b1;
                        wr_ptr_nxt = wr_ptr_r + PTR_ONE;
                    end else begin
                        o_trunc_nxt = 1'b1;
                    end
                end else begin
                    wr_ptr_nxt = wr_ptr_r;
                end
                // The closing mark includes a word written in the same cycle.
                if (mark_s) begin
                    len_lat_nxt = wr_ptr_nxt;
                    o_data_nxt  = {HDR_TAG, ch_lat_r, len_to_hdr(wr_ptr_nxt)};
                    o_valid_nxt = 1'b1;
                    state_nxt   = ST_HDR;
                end else begin
                    state_nxt   = ST_FILL;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    if (len_lat_r != PTR_ZERO) begin
                        o_data_nxt = rd_data_r;
                        rd_ptr_nxt = rd_ptr_r + PTR_ONE;
                        state_nxt  = ST_SEND;
                    end else begin
                        o_data_nxt  = 32'd0;
                        o_valid_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end
                end else begin
                    state_nxt = ST_HDR;
                end
            end
            ST_SEND: begin
                // rd_ptr_r counts words already loaded into o_data_r.
                if (xfer_s) begin
                    if (rd_ptr_r == len_lat_r) begin
                        o_data_nxt  = 32'd0;
                        o_valid_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        o_data_nxt = rd_data_r;
                        rd_ptr_nxt = rd_ptr_r + PTR_ONE;
                        state_nxt  = ST_SEND;
                    end
                end else begin
                    state_nxt = ST_SEND;
                end
            end
            default: begin
                o_data_nxt  = 32'd0;
                o_valid_nxt = 1'b0;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: mark edge detector, pointers, latches and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d_r   <= 1'b1;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            len_lat_r  <= PTR_ZERO;
            ch_lat_r   <= 8'd0;
            o_data_r   <= 32'd0;
            o_valid_r  <= 1'b0;
            o_trunc_r  <= 1'b0;
            drop_cnt_r <= 16'd0;
            o_busy_r   <= 1'b0;
            rd_data_r  <= 32'd0;
        end else begin
            sync_d_r   <= bus.i_sync;
            wr_ptr_r   <= wr_ptr_nxt;
            rd_ptr_r   <= rd_ptr_nxt;
            len_lat_r  <= len_lat_nxt;
            ch_lat_r   <= ch_lat_nxt;
            o_data_r   <= o_data_nxt;
            o_valid_r  <= o_valid_nxt;
            o_trunc_r  <= o_trunc_nxt;
            drop_cnt_r <= drop_cnt_nxt;
            o_busy_r   <= (state_nxt == ST_HDR) || (state_nxt == ST_SEND);
            // Write-through so a word stored this cycle is visible at once.
            if (we_s && (wr_addr_s == rd_addr_s)) begin
                rd_data_r <= bus.i_data;
            end else begin
                rd_data_r <= mem_r[rd_addr_s];
            end
        end
    end

    // Frame buffer write port.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wr_addr_s] <= bus.i_data;
        end
    end

endmodule

// File: tb/tb_frame_tx_packer.sv
// Self-checking bench for frame_tx_packer: frames are driven, the expected
// header and payload words are queued, and a negedge monitor compares every
// transfer against the queue.
module tb_frame_tx_packer;

    logic        clk;
    logic        rst_n;
    logic        o_busy;
    logic        o_trunc;
    logic [15:0] o_drop_cnt;
    int          total;
    int          bad;
    logic [31:0] exp_q [$];

    frame_tx_packer_if bus ();

    frame_tx_packer #(.ADDR_W(8), .HDR_TAG(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .o_busy     (o_busy),
        .o_trunc    (o_trunc),
        .o_drop_cnt (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_rcv_rdy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word got=%08h want=<none>", bus.o_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.o_data !== e) begin
                    bad++;
                    $display("FAIL word got=%08h want=%08h", bus.o_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark(input logic [7:0] ch);
        bus.i_ch   = ch;
        bus.i_sync = 1'b0;
        tick();
        bus.i_sync = 1'b1;
    endtask

    // Open a frame, stream n words from base, close it; queue expectations.
    task automatic send_frame(input logic [7:0] ch, input int n, input logic [31:0] base);
        int kept;
        kept = (n > 256) ? 256 : n;
        mark(ch);
        tick();
        for (int i = 0; i < n; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = base + 32'(i);
            tick();
        end
        bus.i_valid = 1'b0;
        exp_q.push_back({8'hA5, ch, 16'(kept)});
        for (int i = 0; i < kept; i++) exp_q.push_back(base + 32'(i));
        mark(8'hEE);
    endtask

    // Wait until the queue empties; reports whether the budget expired.
    task automatic wait_drain(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ((bus.o_valid !== 1'b0) || (o_busy !== 1'b0) || (o_trunc !== 1'b0) || (o_drop_cnt !== 16'd0) || (bus.o_data !== 32'd0)) begin
            bad++;
            $display("FAIL reset_values got v=%b b=%b t=%b d=%0d data=%08h want all zero", bus.o_valid, o_busy, o_trunc, o_drop_cnt, bus.o_data);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ((bus.o_valid !== 1'b0) || (o_busy !== 1'b0) || (o_drop_cnt !== 16'd0)) begin
                bad++;
                $display("FAIL idle_after_reset cyc=%0d got v=%b b=%b d=%0d want 0 0 0", i, bus.o_valid, o_busy, o_drop_cnt);
            end
        end
        tick();
    endtask

    task automatic test_basic();
        int  cnt;
        bit  seen;
        bus.i_rcv_rdy = 1'b1;
        send_frame(8'd10, 4, 32'h01020304);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                seen = 1'b1;
                break;
            end
        end
        cnt = 0;
        while (seen && bus.o_valid && (cnt < 50)) begin
            cnt++;
            @(negedge clk);
        end
        total++;
        if (cnt != 5) begin
            bad++;
            $display("FAIL basic_burst_len got=%0d want=5", cnt);
        end
        #1;
        total++;
        if ((exp_q.size() != 0) || (bus.o_valid !== 1'b0) || (o_busy !== 1'b0)) begin
            bad++;
            $display("FAIL basic_end got q=%0d v=%b b=%b want 0 0 0", exp_q.size(), bus.o_valid, o_busy);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit to;
        bus.i_rcv_rdy = 1'b0;
        send_frame(8'd10, 4, 32'h01020304);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ((bus.o_valid !== 1'b1) || (bus.o_data !== 32'hA50A0004)) begin
                bad++;
                $display("FAIL hdr_hold cyc=%0d got v=%b d=%08h want 1 a50a0004", i, bus.o_valid, bus.o_data);
            end
            @(negedge clk);
        end
        tick();
        bus.i_rcv_rdy = 1'b1;
        wait_drain(50, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL bp_drain got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_trunc();
        bit to;
        bus.i_rcv_rdy = 1'b1;
        send_frame(8'd3, 260, 32'hC0DE0000);
        #1;
        total++;
        if (o_trunc !== 1'b1) begin
            bad++;
            $display("FAIL trunc_in_hdr got=%b want=1", o_trunc);
        end
        wait_drain(400, to);
        total++;
        if (to || (o_trunc !== 1'b1)) begin
            bad++;
            $display("FAIL trunc_drain got left=%0d trunc=%b want 0 1", exp_q.size(), o_trunc);
        end
    endtask

    task automatic test_empty();
        bit to;
        bus.i_rcv_rdy = 1'b1;
        mark(8'd12);
        bus.i_sync = 1'b1;
        tick();
        exp_q.push_back(32'hA50C0000);
        mark(8'hEE);
        #1;
        total++;
        if (o_trunc !== 1'b0) begin
            bad++;
            $display("FAIL trunc_clear got=%b want=0", o_trunc);
        end
        wait_drain(20, to);
        @(negedge clk);
        total++;
        if (to || (bus.o_valid !== 1'b0) || (o_busy !== 1'b0)) begin
            bad++;
            $display("FAIL empty_frame got left=%0d v=%b b=%b want 0 0 0", exp_q.size(), bus.o_valid, o_busy);
        end
        tick();
    endtask

    task automatic test_drop();
        bit to;
        bus.i_rcv_rdy = 1'b0;
        send_frame(8'd5, 4, 32'hAAAA0000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_valid) break;
        end
        tick();
        bus.i_rcv_rdy = 1'b1;
        tick();
        bus.i_rcv_rdy = 1'b0;
        mark(8'd9);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = 32'hDEAD0000 + 32'(i);
            tick();
        end
        bus.i_valid = 1'b0;
        total++;
        if ((o_drop_cnt !== 16'd1) || (o_busy !== 1'b1)) begin
            bad++;
            $display("FAIL drop_count got cnt=%0d busy=%b want 1 1", o_drop_cnt, o_busy);
        end
        bus.i_rcv_rdy = 1'b1;
        wait_drain(50, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL drop_drain got left=%0d want 0", exp_q.size());
        end
        send_frame(8'd7, 2, 32'h77770000);
        wait_drain(50, to);
        total++;
        if (to || (o_drop_cnt !== 16'd1)) begin
            bad++;
            $display("FAIL after_drop got left=%0d cnt=%0d want 0 1", exp_q.size(), o_drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bus.i_rcv_rdy = 1'b0;
        send_frame(8'd4, 3, 32'h55550000);
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ((bus.o_valid !== 1'b0) || (o_busy !== 1'b0) || (o_drop_cnt !== 16'd0)) begin
            bad++;
            $display("FAIL mid_reset got v=%b b=%b d=%0d want 0 0 0", bus.o_valid, o_busy, o_drop_cnt);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        bus.i_rcv_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bus.o_valid !== 1'b0) begin
                bad++;
                $display("FAIL no_resend cyc=%0d got v=%b want 0", i, bus.o_valid);
            end
        end
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.i_sync    = 1'b1;
        bus.i_data    = 32'd0;
        bus.i_valid   = 1'b0;
        bus.i_ch      = 8'd0;
        bus.i_rcv_rdy = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_trunc();
        test_empty();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
